ca_correlator: RTL and testbench
================================

CA_CORRELATOR -- requirements
Module: ca_correlator

Interface
REQ-001 Parameter SAMP_W, default 4, width of the signed two's-complement I/Q input samples.
REQ-002 Parameter ACC_W, default 16, width of the signed accumulators and dump outputs; SHALL be at least SAMP_W+11.
REQ-003 clock  input  1  rising-edge clock; one C/A chip per cycle, in lockstep with the upstream C/A code generator.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 enable  input  1  1 runs the correlator; 0 returns it to IDLE.
REQ-006 samp_valid  input  1  the current samp_i/samp_q pair is valid.
REQ-007 samp_i  input  SAMP_W  signed in-phase sample.
REQ-008 samp_q  input  SAMP_W  signed quadrature sample.
REQ-009 ca_chip  input  1  upstream C/A code chip; 0 maps to +1, 1 maps to -1.
REQ-010 code_shift  input  10  upstream chip index, 0..1022, wraps 1022->0.
REQ-011 dump_ready  input  1  consumer accepts the dump when dump_valid=1.
REQ-012 overrun_clr  input  1  clears the overrun flag.
REQ-013 dump_valid  output  1  dump_i/dump_q/dump_n hold an unconsumed epoch result.
REQ-014 dump_i  output  ACC_W  signed I correlation sum for the last completed epoch.
REQ-015 dump_q  output  ACC_W  signed Q correlation sum for the last completed epoch.
REQ-016 dump_n  output  11  number of valid samples accumulated in the dumped epoch.
REQ-017 overrun  output  1  sticky: an epoch result was overwritten before it was consumed.
REQ-018 busy  output  1  1 while in the ARM or ACCUM state.

Function
REQ-019 The FSM SHALL have three states: IDLE, ARM and ACCUM.
REQ-020 Transitions:
  - IDLE->ARM when enable=1.
  - ARM->ACCUM on a cycle with enable=1 and code_shift=0.
  - Any state->IDLE on a cycle with enable=0.
REQ-021 Accumulation applies to the ARM->ACCUM cycle and to every ACCUM cycle with enable=1.
  - If samp_valid=1: acc_i += s(samp_i), acc_q += s(samp_q), acc_n += 1.
  - s(x) = x sign-extended to ACC_W when ca_chip=0, or its two's-complement negation when ca_chip=1.
  - The input -2^(SAMP_W-1) negates to +2^(SAMP_W-1) without wrap.
REQ-022 Epoch end is a cycle in ACCUM with enable=1 and code_shift=1022.
  - That cycle's contribution is included.
  - The final sums load dump_i/dump_q/dump_n and dump_valid=1 on the next edge.
  - acc_i/acc_q/acc_n clear to 0 on the same edge; the FSM stays in ACCUM.
REQ-023 The dump-to-output latency SHALL be 1 cycle after the code_shift=1022 cycle.
REQ-024 dump outputs SHALL remain stable while dump_valid=1 and dump_ready=0, except as set by REQ-026.
REQ-025 On dump_valid=1 and dump_ready=1 with no epoch end that cycle, dump_valid clears next cycle.
REQ-026 Epoch end while dump_valid=1:
  - dump_ready=1 the same cycle: the new result loads, dump_valid stays 1, overrun is unchanged.
  - dump_ready=0: the new result overwrites the old one and overrun sets.
REQ-027 overrun, once set, SHALL stay set until overrun_clr=1.
  - overrun_clr and a new overrun event in the same cycle: overrun stays set.
REQ-028 Entering IDLE clears acc_i/acc_q/acc_n; dump outputs, dump_valid and overrun are retained and the handshake continues.
REQ-029 code_shift discontinuities in ACCUM (code_shift reloaded upstream) SHALL NOT restart the epoch; only code_shift=1022 ends it.
REQ-030 Accumulators SHALL NOT saturate; with ACC_W>=SAMP_W+11 one epoch cannot overflow.

Reset
REQ-031 reset=1 SHALL asynchronously force:
  - state=IDLE, busy=0;
  - acc_i=acc_q=0, acc_n=0;
  - dump_i=dump_q=0, dump_n=0, dump_valid=0;
  - overrun=0.
REQ-032 Reset asserted mid-epoch SHALL discard the partial sums; after release the block waits for enable and a code_shift=0 before accumulating.

Verification
REQ-033 Constant-sample epoch: enable=1, samp_valid=1, samp_i=+1, samp_q=-2, ca_chip=0, code_shift counting 0..1022 -> one cycle after code_shift=1022, dump_valid=1, dump_i=1023, dump_q=-2046, dump_n=1023.
REQ-034 Chip inversion and extreme input: ca_chip=1, samp_i=-8, samp_q=+3 for a full epoch -> dump_i=+8184, dump_q=-3069, dump_n=1023.
REQ-035 Mid-epoch arming: enable rises at code_shift=500 -> no accumulation until code_shift=0; the first dump then arrives one cycle after the next code_shift=1022, with dump_n=1023.
REQ-036 Gapped samples: samp_valid alternates 1,0 starting 1 at code_shift=0, samp_i=+2 -> dump_n=512, dump_i=1024.
REQ-037 Overrun: hold dump_ready=0 across two epoch ends -> the second result replaces the first and overrun=1; pulsing overrun_clr then gives overrun=0; dump_ready=1 then gives dump_valid=0 next cycle.
REQ-038 Reset mid-operation: assert reset at code_shift=700 -> all outputs are 0 immediately; after release plus a full epoch, dump_n=1023 with no leftover partial sums.

Source files
------------

// File: rtl/ca_correlator_if.sv
`default_nettype none
// ============================================================================
// Module   : ca_correlator_if
// Brief    : Sample/chip stream in and epoch dump handshake out for the
//            C/A correlator.
// Revision : 1.0
// ============================================================================
interface ca_correlator_if #(
  parameter int SAMP_W = 4,
  parameter int ACC_W  = 16
);
  logic                     enable;
  logic                     samp_valid;
  logic signed [SAMP_W-1:0] samp_i;
  logic signed [SAMP_W-1:0] samp_q;
  logic                     ca_chip;
  logic [9:0]               code_shift;
  logic                     dump_ready;
  logic                     overrun_clr;
  logic                     dump_valid;
  logic signed [ACC_W-1:0]  dump_i;
  logic signed [ACC_W-1:0]  dump_q;
  logic [10:0]              dump_n;
  logic                     overrun;
  logic                     busy;

  modport master (
    output enable, samp_valid, samp_i, samp_q, ca_chip, code_shift,
           dump_ready, overrun_clr,
    input  dump_valid, dump_i, dump_q, dump_n, overrun, busy
  );

  modport slave (
    input  enable, samp_valid, samp_i, samp_q, ca_chip, code_shift,
           dump_ready, overrun_clr,
    output dump_valid, dump_i, dump_q, dump_n, overrun, busy
  );
endinterface
`default_nettype wire

// File: rtl/ca_correlator.sv
`default_nettype none
// ============================================================================
// Module   : ca_correlator
// Brief    : Code-epoch I/Q correlator; despreads samples by the C/A chip and
//            dumps one sum per 1023-chip epoch through a valid/ready handshake.
// Revision : 1.0
// ============================================================================
module ca_correlator #(
  parameter int SAMP_W = 4,
  parameter int ACC_W  = 16
) (
  input  wire logic       clock,
  input  wire logic       reset,
  ca_correlator_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_ACCUM = 2'd2
  } state_t;

  localparam logic [9:0] C_FIRST_CHIP = 10'd0;
  localparam logic [9:0] C_LAST_CHIP  = 10'd1022;

  state_t                  r_state;
  logic                    r_busy;
  logic signed [ACC_W-1:0] r_acc_i;
  logic signed [ACC_W-1:0] r_acc_q;
  logic [10:0]             r_acc_n;
  logic signed [ACC_W-1:0] r_dump_i;
  logic signed [ACC_W-1:0] r_dump_q;
  logic [10:0]             r_dump_n;
  logic                    r_dump_valid;
  logic                    r_overrun;

  logic signed [ACC_W-1:0] w_ext_i;
  logic signed [ACC_W-1:0] w_ext_q;
  logic signed [ACC_W-1:0] w_add_i;
  logic signed [ACC_W-1:0] w_add_q;
  logic signed [ACC_W-1:0] w_sum_i;
  logic signed [ACC_W-1:0] w_sum_q;
  logic [10:0]             w_sum_n;
  logic                    w_accum;
  logic                    w_epoch_end;
  logic                    w_ovr_evt;

  // Negating after widening keeps the most negative sample from wrapping.
  assign w_ext_i = {{(ACC_W-SAMP_W){bus.samp_i[SAMP_W-1]}}, bus.samp_i};
  assign w_ext_q = {{(ACC_W-SAMP_W){bus.samp_q[SAMP_W-1]}}, bus.samp_q};
  assign w_add_i = !bus.samp_valid ? '0 : (bus.ca_chip ? -w_ext_i : w_ext_i);
  assign w_add_q = !bus.samp_valid ? '0 : (bus.ca_chip ? -w_ext_q : w_ext_q);
  assign w_sum_i = r_acc_i + w_add_i;
  assign w_sum_q = r_acc_q + w_add_q;
  assign w_sum_n = r_acc_n + {10'd0, bus.samp_valid};

  assign w_accum     = bus.enable &&
                       ((r_state == ST_ARM && bus.code_shift == C_FIRST_CHIP) ||
                        r_state == ST_ACCUM);
  assign w_epoch_end = bus.enable && (r_state == ST_ACCUM) &&
                       (bus.code_shift == C_LAST_CHIP);
  assign w_ovr_evt   = w_epoch_end && r_dump_valid && !bus.dump_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_acc_i      <= '0;
      r_acc_q      <= '0;
      r_acc_n      <= '0;
      r_dump_i     <= '0;
      r_dump_q     <= '0;
      r_dump_n     <= '0;
      r_dump_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (!bus.enable) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        r_acc_i <= '0;
        r_acc_q <= '0;
        r_acc_n <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_ARM;
            r_busy  <= 1'b1;
          end
          ST_ARM: begin
            if (bus.code_shift == C_FIRST_CHIP) r_state <= ST_ACCUM;
          end
          ST_ACCUM: r_state <= ST_ACCUM;
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase

        // Only chip 1022 closes an epoch; upstream code reloads do not.
        if (w_epoch_end) begin
          r_acc_i <= '0;
          r_acc_q <= '0;
          r_acc_n <= '0;
        end else if (w_accum) begin
          r_acc_i <= w_sum_i;
          r_acc_q <= w_sum_q;
          r_acc_n <= w_sum_n;
        end
      end

      if (w_epoch_end) begin
        r_dump_i     <= w_sum_i;
        r_dump_q     <= w_sum_q;
        r_dump_n     <= w_sum_n;
        r_dump_valid <= 1'b1;
      end else if (r_dump_valid && bus.dump_ready) begin
        r_dump_valid <= 1'b0;
      end

      r_overrun <= w_ovr_evt | (r_overrun & ~bus.overrun_clr);
    end
  end

  assign bus.dump_valid = r_dump_valid;
  assign bus.dump_i     = r_dump_i;
  assign bus.dump_q     = r_dump_q;
  assign bus.dump_n     = r_dump_n;
  assign bus.overrun    = r_overrun;
  assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ca_correlator.sv
`default_nettype none
// ============================================================================
// Module   : tb_ca_correlator
// Brief    : Randomised and directed epochs against a queue-based epoch model.
// Revision : 1.0
// ============================================================================
module tb_ca_correlator;

  localparam int SAMP_W = 4;
  localparam int ACC_W  = 16;

  logic clock = 1'b0;
  logic reset;

  ca_correlator_if #(.SAMP_W(SAMP_W), .ACC_W(ACC_W)) bus ();

  ca_correlator #(.SAMP_W(SAMP_W), .ACC_W(ACC_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int cs       = 0;

  // Epoch model: 0 = idle, 1 = waiting for chip 0, 2 = collecting an epoch.
  int m_mode;
  int q_i[$];
  int q_q[$];
  int m_di, m_dq, m_dn;
  bit m_dv, m_ovr;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic void model_reset();
    m_mode = 0;
    q_i.delete();
    q_q.delete();
    m_di = 0; m_dq = 0; m_dn = 0;
    m_dv = 1'b0; m_ovr = 1'b0;
  endfunction

  function automatic void model_step(input bit en, input bit sv, input int si,
                                     input int sq, input bit chip, input int c,
                                     input bit rdy, input bit oclr);
    bit end_ep  = 1'b0;
    bit ovr_evt = 1'b0;
    int si_d = chip ? -si : si;
    int sq_d = chip ? -sq : sq;
    if (!en) begin
      m_mode = 0;
      q_i.delete();
      q_q.delete();
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (c == 0) begin
        m_mode = 2;
        if (sv) begin q_i.push_back(si_d); q_q.push_back(sq_d); end
      end
    end else begin
      if (sv) begin q_i.push_back(si_d); q_q.push_back(sq_d); end
      end_ep = (c == 1022);
    end
    if (end_ep) begin
      ovr_evt = m_dv && !rdy;
      m_di = 0; m_dq = 0;
      foreach (q_i[k]) m_di += q_i[k];
      foreach (q_q[k]) m_dq += q_q[k];
      m_dn = q_i.size();
      m_dv = 1'b1;
      q_i.delete();
      q_q.delete();
    end else if (m_dv && rdy) begin
      m_dv = 1'b0;
    end
    m_ovr = ovr_evt || (m_ovr && !oclr);
  endfunction

  task automatic compare_all();
    check("dump_valid", bus.dump_valid, m_dv);
    check("dump_i",     bus.dump_i,     m_di);
    check("dump_q",     bus.dump_q,     m_dq);
    check("dump_n",     bus.dump_n,     m_dn);
    check("overrun",    bus.overrun,    m_ovr);
    check("busy",       bus.busy,       m_mode != 0);
  endtask

  function automatic int rs();
    return int'($urandom_range(15)) - 8;
  endfunction

  // One chip: drive after the falling edge, model at the rising edge, compare at the next falling edge.
  task automatic cyc(input bit en, input bit sv, input int si, input int sq,
                     input bit chip, input bit rdy, input bit oclr);
    bus.enable      = en;
    bus.samp_valid  = sv;
    bus.samp_i      = si[SAMP_W-1:0];
    bus.samp_q      = sq[SAMP_W-1:0];
    bus.ca_chip     = chip;
    bus.code_shift  = cs[9:0];
    bus.dump_ready  = rdy;
    bus.overrun_clr = oclr;
    @(posedge clock);
    model_step(en, sv, si, sq, chip, cs, rdy, oclr);
    @(negedge clock);
    compare_all();
    cs = (cs == 1022) ? 0 : cs + 1;
  endtask

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0; bus.samp_valid = 1'b0; bus.samp_i = '0; bus.samp_q = '0;
    bus.ca_chip = 1'b0; bus.code_shift = '0; bus.dump_ready = 1'b0;
    bus.overrun_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    compare_all();
    reset = 1'b0;

    // Constant-sample epoch, armed one chip before chip 0.
    cs = 1022;
    cyc(1, 1, 1, -2, 0, 0, 0);
    for (int k = 0; k < 1023; k++) cyc(1, 1, 1, -2, 0, 0, 0);
    check("const_valid", bus.dump_valid, 1);
    check("const_i", bus.dump_i, 1023);
    check("const_q", bus.dump_q, -2046);
    check("const_n", bus.dump_n, 1023);

    // Inverted chip with the most negative sample.
    for (int k = 0; k < 1023; k++) cyc(1, 1, -8, 3, 1, k == 0, 0);
    check("inv_i", bus.dump_i, 8184);
    check("inv_q", bus.dump_q, -3069);
    check("inv_n", bus.dump_n, 1023);

    // Arm in the middle of the code period.
    while (cs != 500) cyc(0, 1, rs(), rs(), 1'($urandom_range(1)), 1, 0);
    for (int k = 0; k < 523 + 1023; k++)
      cyc(1, 1, rs(), rs(), 1'($urandom_range(1)), 1, 0);
    check("midarm_valid", bus.dump_valid, 1);
    check("midarm_n", bus.dump_n, 1023);

    // Every other chip carries a sample.
    for (int k = 0; k < 1023; k++) cyc(1, (cs % 2) == 0, 2, rs(), 0, 1, 0);
    check("gap_n", bus.dump_n, 512);
    check("gap_i", bus.dump_i, 1024);

    // Two unconsumed epoch ends, then clear and drain.
    for (int k = 0; k < 2046; k++)
      cyc(1, 1'($urandom_range(1)), rs(), rs(), 1'($urandom_range(1)), 0, 0);
    check("ovr_set", bus.overrun, 1);
    check("ovr_valid", bus.dump_valid, 1);
    cyc(1, 1, rs(), rs(), 0, 0, 1);
    check("ovr_clr", bus.overrun, 0);
    cyc(1, 1, rs(), rs(), 0, 1, 0);
    check("drain_valid", bus.dump_valid, 0);

    // Asynchronous reset in the middle of an epoch.
    while (cs != 700) cyc(1, 1, rs(), rs(), 1'($urandom_range(1)), 1'($urandom_range(1)), 0);
    bus.code_shift = 10'd700;
    #2 reset = 1'b1;
    #1;
    check("rst_valid", bus.dump_valid, 0);
    check("rst_i", bus.dump_i, 0);
    check("rst_q", bus.dump_q, 0);
    check("rst_n", bus.dump_n, 0);
    check("rst_ovr", bus.overrun, 0);
    check("rst_busy", bus.busy, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    cs = 701;
    for (int k = 0; k < 322 + 1023; k++) cyc(1, 1, rs(), rs(), 1'($urandom_range(1)), 1, 0);
    check("postrst_n", bus.dump_n, 1023);

    // Random traffic with rare disables and upstream code reloads.
    for (int k = 0; k < 20000; k++) begin
      if ($urandom_range(499) == 0) cs = int'($urandom_range(1022));
      cyc($urandom_range(999) != 0, $urandom_range(3) != 0, rs(), rs(),
          1'($urandom_range(1)), $urandom_range(3) == 0, $urandom_range(15) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
